// File: rtl/seg_capture_if.sv
// Bundle of the sampled 7-segment bus and the decoded results of seg_capture.
// master drives the pins and err_clr; slave is the capture block itself.
interface seg_capture_if;
   logic [3:0] an;
   logic [6:0] seg;
   logic       err_clr;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] digit4;
   logic [3:0] valid;
   logic       frame_done;
   logic       err;

   modport master (
      output an, seg, err_clr,
      input  digit1, digit2, digit3, digit4, valid, frame_done, err
   );

   modport slave (
      input  an, seg, err_clr,
      output digit1, digit2, digit3, digit4, valid, frame_done, err
   );
endinterface

// File: rtl/seg_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus: synchronizes the pins, waits for a
// stable window, decodes the lit digit back to hex and flags frames and illegal bus states.
module seg_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic          clk,
   input logic          reset,
   seg_capture_if.slave bus
);

   localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);
   localparam logic [7:0] CntCap = 8'(STABLE_CYCLES - 1);

   logic [10:0]      sync1_q, sync2_q, prev_q;
   logic [7:0]       cnt_q, cnt_d;
   logic             stable, cap;
   logic [3:0]       samp_an;
   logic [6:0]       samp_seg;
   logic             one_low, multi_low;
   logic [1:0]       pos;
   logic [4:0]       dec;
   logic [3:0][3:0]  digit_q, digit_d;
   logic [3:0]       valid_q, valid_d;
   logic [3:0]       seen_q, seen_d;
   logic             frame_done_q, frame_done_d;
   logic             err_q, err_d;
   logic             err_ev;

   // Active-low gfedcba pattern to {legal, value}.
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = {1'b1, 4'h0};
         7'h79:   r = {1'b1, 4'h1};
         7'h24:   r = {1'b1, 4'h2};
         7'h30:   r = {1'b1, 4'h3};
         7'h19:   r = {1'b1, 4'h4};
         7'h12:   r = {1'b1, 4'h5};
         7'h02:   r = {1'b1, 4'h6};
         7'h78:   r = {1'b1, 4'h7};
         7'h00:   r = {1'b1, 4'h8};
         7'h10:   r = {1'b1, 4'h9};
         7'h08:   r = {1'b1, 4'hA};
         7'h03:   r = {1'b1, 4'hB};
         7'h46:   r = {1'b1, 4'hC};
         7'h21:   r = {1'b1, 4'hD};
         7'h06:   r = {1'b1, 4'hE};
         7'h0E:   r = {1'b1, 4'hF};
         default: r = {1'b0, 4'h0};
      endcase
      return r;
   endfunction

   // Two-flop synchronizer plus previous-sample register; idle bus level is all ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
      end else begin
         sync1_q <= {bus.an, bus.seg};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign stable   = (sync2_q == prev_q);
   assign samp_an  = sync2_q[10:7];
   assign samp_seg = sync2_q[6:0];

   // Stability counter: restart on any change, saturate at the window length.
   always_comb begin
      cnt_d = cnt_q;
      if (!stable) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // One strobe per stable window, on the step into saturation.
   assign cap = stable && (cnt_q == CntCap);

   // Classify the anode pattern; pos is the index of the single low anode bit.
   always_comb begin
      one_low = 1'b1;
      pos     = 2'd0;
      case (samp_an)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: one_low = 1'b0;
      endcase
      multi_low = !one_low && (samp_an != 4'hF);
   end

   assign dec = decode(samp_seg);

   // Capture actions, frame mask and sticky error next-state.
   always_comb begin
      digit_d      = digit_q;
      valid_d      = valid_q;
      err_ev       = 1'b0;
      frame_done_d = (seen_q == 4'hF);
      // A completed mask clears here; a capture this cycle lands in the fresh mask.
      seen_d       = (seen_q == 4'hF) ? 4'h0 : seen_q;
      if (cap) begin
         if (one_low) begin
            seen_d[pos] = 1'b1;
            if (dec[4]) begin
               digit_d[pos] = dec[3:0];
               valid_d[pos] = 1'b1;
            end else begin
               valid_d[pos] = 1'b0;
               err_ev       = 1'b1;
            end
         end else if (multi_low) begin
            err_ev = 1'b1;
         end
      end
      // An error event outranks a simultaneous clear.
      err_d = err_ev | (err_q & ~bus.err_clr);
   end

   // Counter, capture results and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= '0;
         digit_q      <= '0;
         valid_q      <= '0;
         seen_q       <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         valid_q      <= valid_d;
         seen_q       <= seen_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.digit1     = digit_q[3];
   assign bus.digit2     = digit_q[2];
   assign bus.digit3     = digit_q[1];
   assign bus.digit4     = digit_q[0];
   assign bus.valid      = valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: table-driven captures with exact latency checks,
// plus hand-written sequences for bounce, error, reset and code-sweep corners.
module tb_seg_capture;

   localparam int unsigned STABLE = 4;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic [3:0] val;
      int         pos;
   } vec_t;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] val;
   } code_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   seg_capture_if bus ();

   seg_capture #(
      .STABLE_CYCLES(STABLE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail = 0;
   int fd_count = 0;
   int fd0;
   logic [3:0] md [4];
   vec_t frame1 [4];
   vec_t frame3 [4];
   code_t codes [16];

   always @(negedge clk) if (bus.frame_done === 1'b1) fd_count <= fd_count + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      @(negedge clk);
      bus.an  = a;
      bus.seg = s;
   endtask

   function automatic logic [3:0] get_digit(input int p);
      case (p)
         3:       return bus.digit1;
         2:       return bus.digit2;
         1:       return bus.digit3;
         default: return bus.digit4;
      endcase
   endfunction

   function automatic logic [15:0] all_digits();
      return {bus.digit1, bus.digit2, bus.digit3, bus.digit4};
   endfunction

   function automatic logic [15:0] model_digits();
      return {md[3], md[2], md[1], md[0]};
   endfunction

   // Drive one legal digit, check it is not yet visible 5 edges after sampling and is on the 6th.
   task automatic cap_step(input vec_t v, input int hold);
      drive(v.an, v.seg);
      tick(STABLE + 2);
      check("latency_early", get_digit(v.pos), md[v.pos]);
      tick(1);
      md[v.pos] = v.val;
      check("latency_land", get_digit(v.pos), md[v.pos]);
      tick(hold - STABLE - 3);
   endtask

   initial begin
      frame1[0] = '{4'h7, 7'h79, 4'h1, 3};
      frame1[1] = '{4'hB, 7'h24, 4'h2, 2};
      frame1[2] = '{4'hD, 7'h30, 4'h3, 1};
      frame1[3] = '{4'hE, 7'h19, 4'h4, 0};
      frame3[0] = '{4'h7, 7'h12, 4'h5, 3};
      frame3[1] = '{4'hB, 7'h02, 4'h6, 2};
      frame3[2] = '{4'hD, 7'h78, 4'h7, 1};
      frame3[3] = '{4'hE, 7'h00, 4'h8, 0};
      codes[0]  = '{7'h40, 4'h0};
      codes[1]  = '{7'h79, 4'h1};
      codes[2]  = '{7'h24, 4'h2};
      codes[3]  = '{7'h30, 4'h3};
      codes[4]  = '{7'h19, 4'h4};
      codes[5]  = '{7'h12, 4'h5};
      codes[6]  = '{7'h02, 4'h6};
      codes[7]  = '{7'h78, 4'h7};
      codes[8]  = '{7'h00, 4'h8};
      codes[9]  = '{7'h10, 4'h9};
      codes[10] = '{7'h08, 4'hA};
      codes[11] = '{7'h03, 4'hB};
      codes[12] = '{7'h46, 4'hC};
      codes[13] = '{7'h21, 4'hD};
      codes[14] = '{7'h06, 4'hE};
      codes[15] = '{7'h0E, 4'hF};
      for (int i = 0; i < 4; i++) md[i] = 4'h0;

      bus.an = 4'hF;
      bus.seg = 7'h7F;
      bus.err_clr = 1'b0;

      // Reset state and idle blanking.
      tick(3);
      check("rst_digits", all_digits(), 16'h0000);
      check("rst_valid", bus.valid, 4'h0);
      check("rst_err", bus.err, 1'b0);
      check("rst_frame_done", bus.frame_done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      fd0 = fd_count;
      tick(50);
      check("idle_digits", all_digits(), 16'h0000);
      check("idle_valid", bus.valid, 4'h0);
      check("idle_err", bus.err, 1'b0);
      check("idle_frame_done_count", 16'(fd_count - fd0), 16'd0);

      // First full frame.
      fd0 = fd_count;
      for (int i = 0; i < 4; i++) cap_step(frame1[i], 10);
      check("frame1_digits", all_digits(), model_digits());
      check("frame1_valid", bus.valid, 4'hF);
      check("frame1_done_count", 16'(fd_count - fd0), 16'd1);
      check("frame1_err", bus.err, 1'b0);

      // Bouncing segments: no capture until the pattern holds.
      fd0 = fd_count;
      for (int k = 0; k < 10; k++) begin
         drive(4'hE, (k % 2 == 0) ? 7'h79 : 7'h40);
         tick(2);
      end
      check("bounce_digit4", bus.digit4, 4'h4);
      check("bounce_done_count", 16'(fd_count - fd0), 16'd0);
      cap_step('{4'hE, 7'h79, 4'h1, 0}, 10);

      // Multiple anodes low.
      drive(4'hC, 7'h79);
      tick(8);
      check("multi_err", bus.err, 1'b1);
      check("multi_digits", all_digits(), model_digits());
      check("multi_valid", bus.valid, 4'hF);
      drive(4'hF, 7'h7F);
      tick(8);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      tick(1);
      check("err_clear", bus.err, 1'b0);

      // Blank segments on a selected digit are illegal.
      drive(4'hE, 7'h7F);
      tick(8);
      check("illegal_err", bus.err, 1'b1);
      check("illegal_valid", bus.valid, 4'b1110);
      check("illegal_digits", all_digits(), model_digits());
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      tick(1);
      check("err_clear2", bus.err, 1'b0);

      // Error event on the same edge as err_clr keeps err set.
      drive(4'hD, 7'h7F);
      tick(STABLE + 2);
      check("simul_pre_err", bus.err, 1'b0);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      check("simul_err_wins", bus.err, 1'b1);
      check("simul_valid", bus.valid, 4'b1100);

      // Second frame interrupted by reset.
      fd0 = fd_count;
      cap_step('{4'h7, 7'h24, 4'h2, 3}, 10);
      check("frame2_done_count", 16'(fd_count - fd0), 16'd0);
      drive(4'hB, 7'h30);
      tick(3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_digits", all_digits(), 16'h0000);
      check("midrst_valid", bus.valid, 4'h0);
      check("midrst_err", bus.err, 1'b0);
      check("midrst_frame_done", bus.frame_done, 1'b0);
      for (int i = 0; i < 4; i++) md[i] = 4'h0;
      @(negedge clk);
      reset = 1'b1;
      fd0 = fd_count;
      tick(10);
      md[2] = 4'h3;
      check("postrst_digits", all_digits(), model_digits());
      check("postrst_done_count", 16'(fd_count - fd0), 16'd0);
      for (int i = 0; i < 4; i++) cap_step(frame3[i], 10);
      check("frame3_digits", all_digits(), model_digits());
      check("frame3_valid", bus.valid, 4'hF);
      check("frame3_done_count", 16'(fd_count - fd0), 16'd1);
      check("frame3_err", bus.err, 1'b0);

      // Every legal code on digit2.
      for (int i = 0; i < 16; i++) begin
         drive(4'hB, codes[i].seg);
         tick(8);
         check("sweep_digit2", bus.digit2, codes[i].val);
         check("sweep_err", bus.err, 1'b0);
      end
      check("sweep_valid", bus.valid, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
